shot_trajectory_ctrl: RTL and testbench

//  Sequences the basketball sprite. Owns the ball centre coordinates (ball_x, ball_y) fed to the ball renderer.

---
 rtl/shot_trajectory_ctrl.sv | 178 +++++++++++++++++
 tb/tb_shot_trajectory_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_trajectory_ctrl.sv
// Basketball shot sequencer: launches from the rack, integrates position once per frame
// under integer gravity, flags score or miss, holds the result, then re-racks.
module shot_trajectory_ctrl #(
  parameter int START_X       = 60,
  parameter int START_Y       = 400,
  parameter int FLOOR_Y       = 460,
  parameter int X_MIN         = 4,
  parameter int X_MAX         = 635,
  parameter int Y_MIN         = 4,
  parameter int HOOP_X        = 560,
  parameter int HOOP_Y        = 160,
  parameter int HOOP_HW       = 12,
  parameter int GRAV          = 1,
  parameter int GRAV_DIV      = 2,
  parameter int RESULT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       shoot,
  input  logic [7:0] vx_in,
  input  logic [7:0] vy_in,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       busy,
  output logic       score_pulse,
  output logic       miss_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_RESULT} state_t;

  localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int RW = (RESULT_FRAMES > 1) ? $clog2(RESULT_FRAMES) : 1;

  localparam logic signed [11:0] L_X_MIN   = 12'(X_MIN);
  localparam logic signed [11:0] L_X_MAX   = 12'(X_MAX);
  localparam logic signed [11:0] L_Y_MIN   = 12'(Y_MIN);
  localparam logic signed [11:0] L_FLOOR   = 12'(FLOOR_Y);
  localparam logic signed [11:0] L_HOOP_X  = 12'(HOOP_X);
  localparam logic signed [11:0] L_HOOP_HW = 12'(HOOP_HW);
  localparam logic signed [8:0]  L_GRAV    = 9'(GRAV);
  localparam logic [GW-1:0]      L_G_LAST  = GW'(GRAV_DIV - 1);
  localparam logic [RW-1:0]      L_R_LAST  = RW'(RESULT_FRAMES - 1);

  state_t             r_state, w_state;
  logic [9:0]         r_x, r_y, w_x, w_y;
  logic signed [7:0]  r_vx, r_vy, w_vx, w_vy;
  logic [GW-1:0]      r_gcnt, w_gcnt;
  logic [RW-1:0]      r_rcnt, w_rcnt;
  logic               r_busy, w_busy;
  logic               r_score, w_score_n;
  logic               r_miss, w_miss_n;

  logic signed [11:0] w_nx_raw, w_ny_raw, w_dx;
  logic [9:0]         w_nx, w_ny;
  logic               w_x_lo, w_x_hi, w_y_lo, w_y_hi, w_grounded;
  logic               w_in_window, w_score, w_miss;
  logic signed [8:0]  w_vy_sum;
  logic signed [7:0]  w_vy_grav;

  // Unclamped step in 12-bit signed so the out-of-field test sees the true position.
  assign w_nx_raw   = $signed({2'b00, r_x}) + $signed({{4{r_vx[7]}}, r_vx});
  assign w_ny_raw   = $signed({2'b00, r_y}) + $signed({{4{r_vy[7]}}, r_vy});
  assign w_x_lo     = w_nx_raw < L_X_MIN;
  assign w_x_hi     = w_nx_raw > L_X_MAX;
  assign w_y_lo     = w_ny_raw < L_Y_MIN;
  assign w_y_hi     = w_ny_raw > L_FLOOR;
  assign w_grounded = w_ny_raw >= L_FLOOR;
  assign w_nx       = w_x_lo ? 10'(X_MIN) : (w_x_hi ? 10'(X_MAX) : w_nx_raw[9:0]);
  assign w_ny       = w_y_lo ? 10'(Y_MIN) : (w_y_hi ? 10'(FLOOR_Y) : w_ny_raw[9:0]);

  assign w_dx        = w_nx_raw - L_HOOP_X;
  assign w_in_window = (w_dx >= -L_HOOP_HW) && (w_dx <= L_HOOP_HW);
  // Only a descending ball crossing the rim line counts; rising through it never scores.
  assign w_score     = (r_y < 10'(HOOP_Y)) && (w_ny >= 10'(HOOP_Y)) &&
                       (r_vy > 8'sd0) && w_in_window;
  assign w_miss      = w_grounded || w_x_lo || w_x_hi;

  assign w_vy_sum  = $signed({r_vy[7], r_vy}) + L_GRAV;
  assign w_vy_grav = (w_vy_sum > 9'sd127) ? 8'sd127 : w_vy_sum[7:0];

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    w_state   = r_state;
    w_x       = r_x;
    w_y       = r_y;
    w_vx      = r_vx;
    w_vy      = r_vy;
    w_gcnt    = r_gcnt;
    w_rcnt    = r_rcnt;
    w_busy    = r_busy;
    w_score_n = 1'b0;
    w_miss_n  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_x = 10'(START_X);
        w_y = 10'(START_Y);
        if (shoot) begin
          w_vx    = vx_in;
          w_vy    = vy_in;
          w_gcnt  = '0;
          w_busy  = 1'b1;
          w_state = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (frame_tick) begin
          w_x = w_nx;
          w_y = w_ny;
          if (r_gcnt == L_G_LAST) begin
            w_gcnt = '0;
            w_vy   = w_vy_grav;
          end else begin
            w_gcnt = r_gcnt + 1'b1;
          end
          if (w_score) begin
            w_score_n = 1'b1;
            w_state   = S_RESULT;
          end else if (w_miss) begin
            w_miss_n = 1'b1;
            w_state  = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        if (frame_tick) begin
          if (r_rcnt == L_R_LAST) begin
            w_rcnt  = '0;
            w_x     = 10'(START_X);
            w_y     = 10'(START_Y);
            w_vx    = '0;
            w_vy    = '0;
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_rcnt = r_rcnt + 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_x     <= 10'(START_X);
      r_y     <= 10'(START_Y);
      r_vx    <= '0;
      r_vy    <= '0;
      r_gcnt  <= '0;
      r_rcnt  <= '0;
      r_busy  <= 1'b0;
      r_score <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_vx    <= w_vx;
      r_vy    <= w_vy;
      r_gcnt  <= w_gcnt;
      r_rcnt  <= w_rcnt;
      r_busy  <= w_busy;
      r_score <= w_score_n;
      r_miss  <= w_miss_n;
    end
  end

  assign ball_x      = r_x;
  assign ball_y      = r_y;
  assign busy        = r_busy;
  assign score_pulse = r_score;
  assign miss_pulse  = r_miss;

endmodule

// File: tb/tb_shot_trajectory_ctrl.sv
// Bench for shot_trajectory_ctrl: a rack-position instance and a near-hoop instance share
// stimulus; a behavioural model queues expected outputs that are compared every clock.
module tb_shot_trajectory_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, frame_tick, shoot;
  logic [7:0] vx_in, vy_in;
  logic [9:0] x0, y0, x1, y1;
  logic       busy0, busy1, sc0, sc1, ms0, ms1;

  always #5 clk = ~clk;

  shot_trajectory_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .shoot(shoot),
    .vx_in(vx_in), .vy_in(vy_in), .ball_x(x0), .ball_y(y0), .busy(busy0),
    .score_pulse(sc0), .miss_pulse(ms0)
  );

  shot_trajectory_ctrl #(.START_X(548), .START_Y(170)) u_hoop (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .shoot(shoot),
    .vx_in(vx_in), .vy_in(vy_in), .ball_x(x1), .ball_y(y1), .busy(busy1),
    .score_pulse(sc1), .miss_pulse(ms1)
  );

  typedef struct {
    int st, x, y, vx, vy, gc, rc;
    bit busy, score, miss;
  } mdl_t;

  typedef struct {
    int x, y;
    bit busy, score, miss;
  } exp_t;

  mdl_t m0, m1;
  exp_t q0[$], q1[$];
  int   n_checks = 0, n_errors = 0;
  int   sc_cnt0, ms_cnt0, sc_cnt1, ms_cnt1, max_x0;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Behavioural reference with the default field/hoop constants; st 0=idle 1=flight 2=result.
  function automatic mdl_t mdl_next(mdl_t m, int sx, int sy, bit rst, bit tick, bit sh,
                                    int vxi, int vyi);
    mdl_t n;
    int   nx, ny, cx, cy, adx;
    bit   sc, ms;
    n = m;
    n.score = 0;
    n.miss  = 0;
    if (!rst) begin
      n.st = 0; n.x = sx; n.y = sy; n.vx = 0; n.vy = 0; n.gc = 0; n.rc = 0; n.busy = 0;
      return n;
    end
    if (m.st == 0) begin
      if (sh) begin
        n.vx = vxi; n.vy = vyi; n.gc = 0; n.busy = 1; n.st = 1;
      end
    end else if (m.st == 1) begin
      if (tick) begin
        nx = m.x + m.vx;
        ny = m.y + m.vy;
        cx = clampi(nx, 4, 635);
        cy = clampi(ny, 4, 460);
        n.x = cx;
        n.y = cy;
        if (m.gc == 1) begin
          n.gc = 0;
          n.vy = (m.vy + 1 > 127) ? 127 : m.vy + 1;
        end else begin
          n.gc = m.gc + 1;
        end
        adx = (nx > 560) ? nx - 560 : 560 - nx;
        sc  = (m.y < 160) && (cy >= 160) && (m.vy > 0) && (adx <= 12);
        ms  = (ny >= 460) || (nx < 4) || (nx > 635);
        if (sc) begin
          n.score = 1; n.st = 2;
        end else if (ms) begin
          n.miss = 1; n.st = 2;
        end
      end
    end else begin
      if (tick) begin
        if (m.rc == 59) begin
          n.rc = 0; n.x = sx; n.y = sy; n.vx = 0; n.vy = 0; n.busy = 0; n.st = 0;
        end else begin
          n.rc = m.rc + 1;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit tick, input bit sh, input int vxv, input int vyv,
                       input bit rst = 1'b1);
    exp_t e0, e1;
    reset_n    = rst;
    frame_tick = tick;
    shoot      = sh;
    vx_in      = 8'(vxv);
    vy_in      = 8'(vyv);
    m0 = mdl_next(m0, 60, 400, rst, tick, sh, vxv, vyv);
    m1 = mdl_next(m1, 548, 170, rst, tick, sh, vxv, vyv);
    e0.x = m0.x; e0.y = m0.y; e0.busy = m0.busy; e0.score = m0.score; e0.miss = m0.miss;
    e1.x = m1.x; e1.y = m1.y; e1.busy = m1.busy; e1.score = m1.score; e1.miss = m1.miss;
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    @(negedge clk);
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("rack_x", int'(x0), e0.x);
    check("rack_y", int'(y0), e0.y);
    check("rack_busy", int'(busy0), int'(e0.busy));
    check("rack_score", int'(sc0), int'(e0.score));
    check("rack_miss", int'(ms0), int'(e0.miss));
    check("hoop_x", int'(x1), e1.x);
    check("hoop_y", int'(y1), e1.y);
    check("hoop_busy", int'(busy1), int'(e1.busy));
    check("hoop_score", int'(sc1), int'(e1.score));
    check("hoop_miss", int'(ms1), int'(e1.miss));
    sc_cnt0 += int'(sc0); ms_cnt0 += int'(ms0);
    sc_cnt1 += int'(sc1); ms_cnt1 += int'(ms1);
    if (int'(x0) > max_x0) max_x0 = int'(x0);
  endtask

  task automatic frame(input bit sh = 1'b0, input int vxv = 0, input int vyv = 0);
    cycle(1'b1, sh, vxv, vyv);
    cycle(1'b0, sh, vxv, vyv);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 0, 0, 1'b0);
    cycle(1'b0, 1'b0, 0, 0, 1'b0);
    sc_cnt0 = 0; ms_cnt0 = 0; sc_cnt1 = 0; ms_cnt1 = 0; max_x0 = 0;
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; shoot = 1'b0; vx_in = '0; vy_in = '0;

    // Reset from power-up and again mid-flight.
    do_reset();
    check("t1_x", int'(x0), 60);
    check("t1_y", int'(y0), 400);
    check("t1_busy", int'(busy0), 0);
    cycle(1'b0, 1'b1, 3, -5);
    for (int i = 0; i < 5; i++) frame();
    check("t1_flight_busy", int'(busy0), 1);
    do_reset();
    check("t1_rst_x", int'(x0), 60);
    check("t1_rst_y", int'(y0), 400);
    check("t1_rst_busy", int'(busy0), 0);
    cycle(1'b0, 1'b0, 0, 0);
    check("t1_pulses", sc_cnt0 + ms_cnt0, 0);

    // Dead drop: y holds for two ticks then falls 1,1,2,2,3.
    cycle(1'b0, 1'b1, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);
    check("t2_busy", int'(busy0), 1);
    frame(); check("t2_y1", int'(y0), 400);
    frame(); check("t2_y2", int'(y0), 400);
    frame(); check("t2_y3", int'(y0), 401);
    frame(); check("t2_y4", int'(y0), 402);
    frame(); check("t2_y5", int'(y0), 404);
    for (int i = 0; i < 200 && ms_cnt0 == 0; i++) frame();
    check("t2_miss_cnt", ms_cnt0, 1);
    check("t2_floor_y", int'(y0), 460);
    for (int i = 0; i < 59; i++) frame();
    check("t2_hold_busy", int'(busy0), 1);
    check("t2_hold_y", int'(y0), 460);
    frame();
    check("t2_rerack_x", int'(x0), 60);
    check("t2_rerack_y", int'(y0), 400);
    check("t2_rerack_busy", int'(busy0), 0);
    check("t2_miss_once", ms_cnt0, 1);

    // Up through the rim without scoring, down through it to score.
    do_reset();
    cycle(1'b0, 1'b1, 0, -10);
    cycle(1'b0, 1'b0, 0, 0);
    frame(); check("t3_y1", int'(y1), 160);
    frame(); check("t3_y2", int'(y1), 150);
    check("t3_no_early_score", sc_cnt1, 0);
    for (int i = 0; i < 200 && sc_cnt1 == 0 && ms_cnt1 == 0; i++) frame();
    for (int i = 0; i < 10; i++) frame();
    check("t3_score_cnt", sc_cnt1, 1);
    check("t3_miss_cnt", ms_cnt1, 0);
    check("t3_x", int'(x1), 548);

    // Right-wall clamp.
    do_reset();
    cycle(1'b0, 1'b1, 127, -2);
    cycle(1'b0, 1'b0, 0, 0);
    frame(); check("t4_x1", int'(x0), 187);
    frame(); check("t4_x2", int'(x0), 314);
    frame(); check("t4_x3", int'(x0), 441);
    frame(); check("t4_x4", int'(x0), 568);
    check("t4_no_miss_yet", ms_cnt0, 0);
    frame(); check("t4_x5", int'(x0), 635);
    check("t4_miss", ms_cnt0, 1);
    for (int i = 0; i < 60; i++) frame();
    check("t4_max_x", max_x0, 635);
    check("t4_busy", int'(busy0), 0);

    // Shoot noise during FLIGHT and RESULT must not reload.
    do_reset();
    cycle(1'b0, 1'b1, 2, -6);
    cycle(1'b0, 1'b1, -50, -50);
    frame(1'b1, 100, -100); check("t5_x1", int'(x0), 62); check("t5_y1", int'(y0), 394);
    frame(1'b1, -90, 90);   check("t5_x2", int'(x0), 64); check("t5_y2", int'(y0), 388);
    frame(1'b1, 5, 5);      check("t5_x3", int'(x0), 66); check("t5_y3", int'(y0), 383);
    for (int i = 0; i < 200 && ms_cnt0 == 0; i++) frame(1'b1, -7, 9);
    check("t5_miss", ms_cnt0, 1);
    for (int i = 0; i < 30; i++) frame(1'b1, 33, -33);
    check("t5_result_busy", int'(busy0), 1);
    check("t5_miss_once", ms_cnt0, 1);
    for (int i = 0; i < 30; i++) frame();
    check("t5_idle", int'(busy0), 0);

    // Shoot coincident with a tick: no motion on that tick; then left-wall clamp.
    do_reset();
    cycle(1'b1, 1'b1, -127, 0);
    check("t6_x0", int'(x0), 60);
    check("t6_y0", int'(y0), 400);
    check("t6_busy", int'(busy0), 1);
    cycle(1'b0, 1'b0, 0, 0);
    check("t6_still_x", int'(x0), 60);
    frame();
    check("t6_clamp_x", int'(x0), 4);
    check("t6_miss", ms_cnt0, 1);
    for (int i = 0; i < 62; i++) frame();
    check("t6_rerack", int'(busy0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
